// File: rtl/lock_pkg.sv
// lock_pkg: FSM state encoding and digit width shared by the code lock files
package lock_pkg;
    localparam int DIGIT_W = 4;
    typedef enum logic {ENTER = 1'b0, LOCKOUT = 1'b1} state_t;
endpackage

// File: rtl/equality4bit.sv
// equality4bit: combinational equality of two digits
// Ports: a, b - digits under comparison; eq - high when a == b
module equality4bit
    import lock_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               eq
);
    assign eq = (a == b);
endmodule

// File: rtl/code_lock_fsm.sv
// code_lock_fsm: sequential digit-entry lock with programmable code and lockout after repeated failures
// Ports: clk, rst_n (async active-low); din/din_valid digit stream; prog writes din into the code;
//        clear aborts a partial entry; unlock/fail one-cycle result pulses; locked lockout level;
//        idx index of the next digit expected
module code_lock_fsm
    import lock_pkg::*;
#(
    parameter int                       DIGITS      = 4,
    parameter logic [DIGIT_W*DIGITS-1:0] RESET_CODE = 16'h1234,
    parameter int                       MAX_FAIL    = 3,
    parameter int                       LOCK_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DIGIT_W-1:0]         din,
    input  logic                       din_valid,
    input  logic                       prog,
    input  logic                       clear,
    output logic                       unlock,
    output logic                       fail,
    output logic                       locked,
    output logic [$clog2(DIGITS)-1:0]  idx
);
    localparam int IW = $clog2(DIGITS);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(LOCK_CYCLES + 1);
    localparam logic [IW-1:0] LAST      = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [TW-1:0] TIMER_TOP = TW'(LOCK_CYCLES - 1);

    state_t               r_state, w_state_nxt;
    logic [IW-1:0]        r_idx, w_idx_nxt;
    logic [IW-1:0]        r_pptr, w_pptr_nxt;
    logic                 r_mis, w_mis_nxt;
    logic [FW-1:0]        r_fcnt, w_fcnt_nxt;
    logic [TW-1:0]        r_timer, w_timer_nxt;
    logic [DIGIT_W-1:0]   r_code [DIGITS];
    logic [DIGIT_W-1:0]   w_code_nxt [DIGITS];
    logic                 r_unlock, w_unlock_nxt;
    logic                 r_fail, w_fail_nxt;
    logic                 w_eq;

    equality4bit u_eq (
        .a  (din),
        .b  (r_code[r_idx]),
        .eq (w_eq)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_pptr_nxt   = r_pptr;
        w_mis_nxt    = r_mis;
        w_fcnt_nxt   = r_fcnt;
        w_timer_nxt  = r_timer;
        w_code_nxt   = r_code;
        w_unlock_nxt = 1'b0;
        w_fail_nxt   = 1'b0;
        if (r_state == LOCKOUT) begin
            if (r_timer == '0) begin
                w_state_nxt = ENTER;
                w_fcnt_nxt  = '0;
                w_idx_nxt   = '0;
                w_mis_nxt   = 1'b0;
            end else begin
                w_timer_nxt = r_timer - 1'b1;
            end
        end else if (clear) begin
            w_idx_nxt = '0;
            w_mis_nxt = 1'b0;
        end else if (din_valid && prog) begin
            w_code_nxt[r_pptr] = din;
            w_pptr_nxt         = (r_pptr == LAST) ? '0 : r_pptr + 1'b1;
            w_idx_nxt          = '0;
            w_mis_nxt          = 1'b0;
        end else if (din_valid) begin
            if (r_idx == LAST) begin
                w_idx_nxt = '0;
                w_mis_nxt = 1'b0;
                if (!r_mis && w_eq) begin
                    w_unlock_nxt = 1'b1;
                    w_fcnt_nxt   = '0;
                end else begin
                    // Lockout is entered on the same edge that registers the fail pulse,
                    // so locked and fail rise together.
                    w_fail_nxt = 1'b1;
                    w_fcnt_nxt = r_fcnt + 1'b1;
                    if (r_fcnt + 1'b1 == FAIL_MAX) begin
                        w_state_nxt = LOCKOUT;
                        w_timer_nxt = TIMER_TOP;
                    end
                end
            end else begin
                w_idx_nxt = r_idx + 1'b1;
                w_mis_nxt = r_mis | !w_eq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ENTER;
            r_idx    <= '0;
            r_pptr   <= '0;
            r_mis    <= 1'b0;
            r_fcnt   <= '0;
            r_timer  <= '0;
            r_unlock <= 1'b0;
            r_fail   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) r_code[i] <= RESET_CODE[i*DIGIT_W +: DIGIT_W];
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_pptr   <= w_pptr_nxt;
            r_mis    <= w_mis_nxt;
            r_fcnt   <= w_fcnt_nxt;
            r_timer  <= w_timer_nxt;
            r_unlock <= w_unlock_nxt;
            r_fail   <= w_fail_nxt;
            r_code   <= w_code_nxt;
        end
    end

    assign unlock = r_unlock;
    assign fail   = r_fail;
    assign locked = (r_state == LOCKOUT);
    assign idx    = r_idx;
endmodule

// File: doc/code_lock_fsm.md
Name: code_lock_fsm

Overview:
- Sequential digit-entry lock built around the 4-bit equality check.
- Accepts a stream of 4-bit digits.
- Compares each digit against a stored code using one instance of the 4-bit equality comparator.
- Reports unlock or fail after a full code entry, and enforces a lockout window after repeated failures.
- Downstream consumer of the comparator's eq output; first sequential block in the lab chain.

Parameters:
- DIGITS, 4: code length in 4-bit digits, range 2..8.
- RESET_CODE, 16'h1234: code after reset, width 4*DIGITS. Digit 0 is bits [3:0], entered first.
- MAX_FAIL, 3: consecutive failed entries that trigger lockout, range ≥1.
- LOCK_CYCLES, 8: lockout duration in clk cycles, range ≥1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- din, input, 4: entered or programmed digit.
- din_valid, input, 1: din qualifier, one digit per cycle while high.
- prog, input, 1: when high with din_valid, din is written into the code instead of compared.
- clear, input, 1: synchronous abort of partial entry.
- unlock, output, 1: one-cycle pulse, correct code entered.
- fail, output, 1: one-cycle pulse, wrong code entered.
- locked, output, 1: level, high during lockout.
- idx, output, clog2(DIGITS): index of the next digit expected.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State ENTER.
  - idx=0, prog pointer=0, mismatch flag=0, fail count=0, lock timer=0.
  - Code = RESET_CODE.
  - unlock=0, fail=0, locked=0.
- States: ENTER, LOCKOUT.
- ENTER, din_valid=1, prog=0:
  - eq = (din == code[idx]) from the equality sub-module.
  - If idx < DIGITS-1: idx increments and mismatch |= !eq.
  - If idx == DIGITS-1: idx returns to 0 and mismatch clears.
    - Next cycle, unlock=1 if (!mismatch && eq); otherwise fail=1.
- Latency: result pulse appears exactly 1 cycle after the final digit's valid cycle. Pulses are registered, never combinational.
- unlock: fail count clears to 0.
- fail:
  - Fail count increments.
  - If the new count equals MAX_FAIL, the next state is LOCKOUT, locked rises in the same cycle as the fail pulse, and the lock timer loads LOCK_CYCLES-1.
- LOCKOUT:
  - din_valid, prog and clear are ignored.
  - The timer decrements each cycle.
  - When the timer reaches 0: the next state is ENTER, locked falls, fail count clears, idx=0.
  - locked is high for exactly LOCK_CYCLES cycles.
- Programming (ENTER only, din_valid=1, prog=1):
  - code[pptr] <= din.
  - pptr increments and wraps DIGITS-1 → 0.
  - Any partial entry is aborted: idx=0, mismatch=0.
  - No unlock or fail pulse.
  - The fail count is unchanged.
- clear=1 in ENTER: idx=0 and mismatch=0. clear has priority over din_valid in the same cycle. pptr and fail count are unchanged.
- din_valid=0: no state change. Gaps between digits are unlimited.
- Back-to-back entries: the first digit of the next entry may arrive in the same cycle as the previous result pulse.
- Mid-operation rst_n assertion: immediate return to reset values. The code reverts to RESET_CODE.

Decomposition:
- Shared package lock_pkg holds:
  - State encoding: ENTER=1'b0, LOCKOUT=1'b1.
  - Digit width constant DIGIT_W=4.
- Sub-module: the existing 4-bit equality comparator (equality4bit), instantiated once on din vs code[idx].
- Code storage, counters and FSM stay in code_lock_fsm.

Test Plan:
- Reset, then enter 4,3,2,1 (digit0=4, matches RESET_CODE 16'h1234) → unlock=1 one cycle after the 4th digit; fail=0; idx back to 0.
- Enter 4,3,2,0 → fail=1 one cycle after the 4th digit; fail count=1; locked=0.
- Three consecutive wrong entries → locked rises with the 3rd fail pulse and stays high 8 cycles. A correct entry fed during lockout produces no unlock. After lockout, a correct entry → unlock.
- Program 9,9,9,9 (prog=1, 4 valid cycles) → entering 4,3,2,1 gives fail; entering 9,9,9,9 gives unlock.
- Enter 4,3 then clear=1, then 4,3,2,1 → single unlock, no fail. Repeat with a wrong first digit before clear → still unlock.
- Assert rst_n low after 2 digits of a wrong entry → all outputs 0 immediately; code reverts to 16'h1234; next 4,3,2,1 → unlock.
